// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
// UART_RX_PARITY_EN adds the even-parity state to the encoding.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Even-parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick_o once per wrap.
// clr_i restarts the count so ticks align with a detected start edge.
module uart_rx_tick #(
  parameter int unsigned DIV = 130
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and the rx_parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned XTAL_CLK = 20000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIV      = XTAL_CLK / (BAUD * 16)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
`ifdef UART_RX_PARITY_EN
  output logic                 rx_parity_err,
`endif
  output logic                 rx_frame_err
);

  rx_state_e            state_q;
  logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [OS_W-1:0]      os_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tick;
  logic                 start_edge_c;
  logic                 tick_clr_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  assign start_edge_c = rxd_prev_q & ~rxd_s2_q;
  assign tick_clr_c   = (state_q == ST_IDLE) && start_edge_c;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .clr_i     (tick_clr_c),
    .tick_o    (tick)
  );

  // Frame FSM; every sample point is a tick where the oversample count wraps mid-bit.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q       <= ST_IDLE;
      os_cnt_q      <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
      par_bad_q     <= 1'b0;
`endif
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (start_edge_c) begin
            state_q   <= ST_START;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (os_cnt_q == OS_W'(MID_SAMPLE)) begin
              os_cnt_q <= '0;
              state_q  <= rxd_s2_q ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt_q <= os_cnt_q + OS_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + OS_W'(1);
            if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
              shift_q   <= {rxd_s2_q, shift_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + OS_W'(1);
            if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
              par_bad_q <= even_parity(shift_q) ^ rxd_s2_q;
              state_q   <= ST_STOP;
            end
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + OS_W'(1);
            if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
              state_q  <= ST_IDLE;
              os_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
              // A parity mismatch outranks the stop level so pulses stay exclusive.
              if (par_bad_q) begin
                rx_parity_err <= 1'b1;
              end else
`endif
              if (rxd_s2_q) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                rx_frame_err <= 1'b1;
              end
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level event model.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;

  localparam int unsigned XTAL   = 640000;
  localparam int unsigned BAUDR  = 10000;
  localparam int unsigned DIV_TB = XTAL / (BAUDR * 16);
  localparam int unsigned BIT    = DIV_TB * 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FBITS = 11;
`else
  localparam int unsigned FBITS = 10;
`endif

  typedef struct {
    int          kind;   // 0 valid, 1 frame error, 2 parity error
    logic [7:0]  data;
    longint      lo;
    longint      hi;
  } ev_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_l;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`else
  logic       rx_parity_err;
  assign rx_parity_err = 1'b0;
`endif

  int         n_assert = 0;
  int         n_fail   = 0;
  longint     cyc      = 0;
  logic [7:0] model_data = 8'h00;
  ev_t        expq[$];

  always #5 sys_clk = ~sys_clk;

  uart_rx #(.XTAL_CLK(XTAL), .BAUD(BAUDR)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_l     (sys_rst_l),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err (rx_parity_err),
`endif
    .rx_frame_err  (rx_frame_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Compare process: every pulse must match the head of the expected-event queue.
  initial begin
    forever begin
      int  np;
      ev_t e;
      @(posedge sys_clk);
      #1;
      cyc++;
      np = 0;
      if (rx_valid)      np++;
      if (rx_frame_err)  np++;
      if (rx_parity_err) np++;
      if (!sys_rst_l) begin
        model_data = 8'h00;
        chk("reset_outputs", {rx_data, 7'b0, np == 0}, {8'h00, 7'b0, 1'b1});
      end else begin
        if (np > 1) begin
          chk("pulse_exclusive", np, 1);
        end else if (np == 1) begin
          if (expq.size() == 0) begin
            chk("unexpected_pulse", {rx_valid, rx_frame_err, rx_parity_err}, 0);
          end else begin
            e = expq.pop_front();
            chk("pulse_kind", rx_valid ? 0 : (rx_frame_err ? 1 : 2), e.kind);
            chk("pulse_time_in_window", (cyc >= e.lo && cyc <= e.hi), 1);
            if (e.kind == 0) model_data = e.data;
          end
        end else if (expq.size() > 0 && cyc > expq[0].hi) begin
          chk("missed_pulse_kind", 32'hdead, expq[0].kind);
          void'(expq.pop_front());
        end
        chk("rx_data", rx_data, model_data);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v, input logic par_ok);
    ev_t e;
    logic [7:0] dv;
    dv = d;
    e.data = d;
    e.lo   = cyc + longint'((FBITS * 16 - 8) * DIV_TB);
    e.hi   = e.lo + longint'(2 * DIV_TB + 8);
`ifdef UART_RX_PARITY_EN
    e.kind = !par_ok ? 2 : (stop_v ? 0 : 1);
`else
    e.kind = stop_v ? 0 : 1;
`endif
    expq.push_back(e);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(dv[i], BIT);
`ifdef UART_RX_PARITY_EN
    hold((^dv) ^ ~par_ok, BIT);
`endif
    hold(stop_v, BIT);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (expq.size() > 0 && t < 3 * FBITS * BIT) begin
      @(negedge sys_clk);
      t++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    hold(1'b1, BIT);
  endtask

  initial begin
    logic [7:0] d;
    logic       sv, pok;
    int         gap;
    rxd       = 1'b1;
    sys_rst_l = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    hold(1'b1, 10);
    chk("post_reset_data", rx_data, 8'h00);

    send(8'h55, 1'b1, 1'b1);
    wait_idle();
    chk("lit_0x55", rx_data, 8'h55);

    send(8'hA3, 1'b0, 1'b1);
    hold(1'b0, 3 * BIT);
    wait_idle();
    chk("lit_frame_err_keeps", rx_data, 8'h55);

    hold(1'b0, 15);
    hold(1'b1, BIT);
    send(8'h3C, 1'b1, 1'b1);
    wait_idle();
    chk("lit_after_glitch", rx_data, 8'h3C);

    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    wait_idle();
    chk("lit_back_to_back", rx_data, 8'hFF);

    // Abandon 0x81 mid bit 3 with a reset pulse.
    d = 8'h81;
    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(d[i], BIT);
    hold(d[3], BIT / 2);
    sys_rst_l = 1'b0;
    hold(1'b1, 8);
    sys_rst_l = 1'b1;
    hold(1'b1, BIT);
    chk("lit_reset_clears", rx_data, 8'h00);
    send(8'h0F, 1'b1, 1'b1);
    wait_idle();
    chk("lit_after_reset", rx_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    wait_idle();
    chk("lit_parity_bad_keeps", rx_data, 8'h0F);
    send(8'h07, 1'b1, 1'b1);
    wait_idle();
    chk("lit_parity_good", rx_data, 8'h07);
`endif

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        hold(1'b0, $urandom_range(1, 20));
        hold(1'b1, BIT);
      end
      d   = 8'($urandom);
      sv  = ($urandom_range(0, 7) != 0);
      pok = ($urandom_range(0, 7) != 0);
      send(d, sv, pok);
      gap = sv ? $urandom_range(0, 2 * BIT) : BIT;
      if (gap > 0) hold(1'b1, gap);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter XTAL_CLK, default 20000000, sys_clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter DIV, default XTAL_CLK/(BAUD*16) (130 at defaults), sys_clk cycles per oversample tick.
REQ-004 sys_clk  input  1  clock; all logic on rising edge.
REQ-005 sys_rst_l  input  1  reset, asynchronous, active-low.
REQ-006 rxd  input  1  asynchronous serial line, idle high, 8N1 LSB first.
REQ-007 rx_data  output  8  last correctly received byte.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-009 rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 rx_parity_err  output  1  one-cycle pulse: parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-011 rxd SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 Tick counter SHALL count 0..DIV-1 and emit a one-cycle tick at DIV-1; it SHALL be cleared when a start edge is detected.
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP; 4-bit oversample counter, 3-bit bit index.
REQ-014 IDLE: a synchronized high-to-low transition SHALL enter START with counters cleared; a line held low SHALL NOT start a frame.
REQ-015 START: at oversample count 7 (mid-bit), line low -> DATA; line high -> IDLE (glitch reject, no output pulse).
REQ-016 DATA: sample every 16 ticks at mid-bit, shift in LSB first; after bit 7 -> PARITY if compiled in, else STOP.
REQ-017 STOP: at mid-bit sample, high -> rx_data loaded and rx_valid pulsed on the next sys_clk; low -> rx_frame_err pulsed, rx_data unchanged; both -> IDLE.
REQ-018 Return to IDLE at stop mid-bit SHALL allow a following start bit with zero idle time to be captured.
REQ-019 rx_valid, rx_frame_err, rx_parity_err SHALL be mutually exclusive and never longer than one cycle.
REQ-020 No flow control: an unread rx_data is overwritten by the next valid byte.

Reset
REQ-021 Reset SHALL force IDLE, counters 0, shift register 0, rx_data 8'h00, all pulse outputs 0, synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no output pulse; the next start edge after release starts cleanly.

Configuration
REQ-023 Macro UART_RX_PARITY_EN: defined -> one even-parity bit after bit 7, sampled mid-bit; mismatch pulses rx_parity_err, suppresses rx_valid, keeps rx_data, STOP still checked for timing only.
REQ-024 Macro undefined -> no PARITY state, rx_parity_err port absent, frame is 10 bits.

Structure
REQ-025 Package uart_pkg SHALL hold the state encoding, OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8.
REQ-026 Tick generation SHALL be sub-module uart_rx_tick (DIV counter, clear input, tick output).

Verification (defaults, bit period 2080 sys_clk)
REQ-027 Frame 0x55, stop high -> one rx_valid pulse ~10 bit periods after start edge, rx_data=0x55, no error pulse.
REQ-028 rxd low 500 cycles then high -> no pulse, FSM back in IDLE, next frame 0x3C received correctly.
REQ-029 Frame 0xA3 with stop low -> rx_frame_err pulse, rx_valid 0, rx_data remains 0x55; line held low afterwards triggers nothing.
REQ-030 Frames 0x00 and 0xFF back-to-back, no idle -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-031 Reset pulse during bit 3 of 0x81, then frame 0x0F -> outputs zero during reset, single rx_valid with 0x0F.
REQ-032 UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_parity_err pulse, no rx_valid; with parity 1 -> rx_valid, rx_data=0x07.
